// File: rtl/drex4_pkg.sv
// Shared constants and types for the drex4 sprite fetch path.
package drex4_pkg;

  localparam int SPR_W           = 32;
  localparam int SPR_H           = 32;
  localparam int N_FRAMES        = 4;
  localparam int FRAME_DIV       = 8;
  localparam int TRANSPARENT_IDX = 0;
  localparam int BBOX_IDX        = 6;

  typedef logic [3:0] pal_idx_t;
  typedef logic [9:0] coord_t;

  // Counter width helper that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/drex4_sprite_fetch_if.sv
// Beam/sprite inputs, sprite ROM port and palette-index outputs of the sprite fetch block.
interface drex4_sprite_fetch_if #(
  parameter int ROM_AW = 12
);
  import drex4_pkg::*;

  logic              frame_start;
  logic              pix_valid;
  coord_t            DrawX;
  coord_t            DrawY;
  coord_t            sprite_x;
  coord_t            sprite_y;
  logic              sprite_dir;
  logic              anim_en;
  logic [ROM_AW-1:0] rom_addr;
  pal_idx_t          rom_data;
  pal_idx_t          index;
  logic              opaque;
  logic              index_valid;

  modport master (
    output frame_start, pix_valid, DrawX, DrawY, sprite_x, sprite_y,
           sprite_dir, anim_en, rom_data,
    input  rom_addr, index, opaque, index_valid
  );

  modport slave (
    input  frame_start, pix_valid, DrawX, DrawY, sprite_x, sprite_y,
           sprite_dir, anim_en, rom_data,
    output rom_addr, index, opaque, index_valid
  );

endinterface

// File: rtl/drex4_anim_ctr.sv
// Animation stepper: divides frame_start pulses by FRAME_DIV and cycles through N_FRAMES.
module drex4_anim_ctr #(
  parameter int N_FRAMES  = 4,
  parameter int FRAME_DIV = 8,
  parameter int FRAME_W   = drex4_pkg::clog2_min1(N_FRAMES)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_start,
  input  logic               anim_en,
  output logic [FRAME_W-1:0] frame
);

  localparam int DIV_W = drex4_pkg::clog2_min1(FRAME_DIV);

  logic [DIV_W-1:0]   div;
  logic [FRAME_W-1:0] frame_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div     <= '0;
      frame_q <= '0;
    end else if (frame_start && anim_en) begin
      if (div == DIV_W'(FRAME_DIV - 1)) begin
        div     <= '0;
        frame_q <= (frame_q == FRAME_W'(N_FRAMES - 1)) ? '0 : frame_q + FRAME_W'(1);
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  assign frame = frame_q;

endmodule

// File: rtl/drex4_sprite_fetch.sv
// Per-pixel sprite ROM fetch with 2-cycle latency; optional debug outline via DREX4_SPRITE_BBOX_EN.
module drex4_sprite_fetch #(
  parameter int SPR_W           = drex4_pkg::SPR_W,
  parameter int SPR_H           = drex4_pkg::SPR_H,
  parameter int N_FRAMES        = drex4_pkg::N_FRAMES,
  parameter int FRAME_DIV       = drex4_pkg::FRAME_DIV,
  parameter int TRANSPARENT_IDX = drex4_pkg::TRANSPARENT_IDX,
  parameter int ROM_AW          = $clog2(SPR_W * SPR_H * N_FRAMES)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  drex4_sprite_fetch_if.slave  bus
);
  import drex4_pkg::*;

  localparam int       FRAME_W = clog2_min1(N_FRAMES);
  localparam int       CW      = clog2_min1(SPR_W);
  localparam int       RW      = clog2_min1(SPR_H);
  localparam pal_idx_t TRANSP  = pal_idx_t'(TRANSPARENT_IDX);

  function automatic logic in_range(input logic signed [10:0] v, input int lim);
    return (v >= 11'sd0) && (int'(v) < lim);
  endfunction

  coord_t             lx;
  coord_t             ly;
  logic               ldir;
  logic [FRAME_W-1:0] frame;

  // Position and facing only change at vertical blank so a frame never tears.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lx   <= '0;
      ly   <= '0;
      ldir <= 1'b0;
    end else if (bus.frame_start) begin
      lx   <= bus.sprite_x;
      ly   <= bus.sprite_y;
      ldir <= bus.sprite_dir;
    end
  end

  drex4_anim_ctr #(
    .N_FRAMES  (N_FRAMES),
    .FRAME_DIV (FRAME_DIV),
    .FRAME_W   (FRAME_W)
  ) u_anim (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (bus.frame_start),
    .anim_en     (bus.anim_en),
    .frame       (frame)
  );

  // ---- stage 0: hit test and address computation ----
  logic signed [10:0] col_p0;
  logic signed [10:0] row_p0;
  logic [CW-1:0]      col_lo_p0;
  logic [CW-1:0]      colm_p0;
  logic [RW-1:0]      row_lo_p0;
  logic               hit_p0;
  logic [ROM_AW-1:0]  addr_p0;

  assign col_p0    = signed'({1'b0, bus.DrawX}) - signed'({1'b0, lx});
  assign row_p0    = signed'({1'b0, bus.DrawY}) - signed'({1'b0, ly});
  assign col_lo_p0 = col_p0[CW-1:0];
  assign row_lo_p0 = row_p0[RW-1:0];
  assign hit_p0    = bus.pix_valid && in_range(col_p0, SPR_W) && in_range(row_p0, SPR_H);
  assign colm_p0   = ldir ? (CW'(SPR_W - 1) - col_lo_p0) : col_lo_p0;
  assign addr_p0   = ROM_AW'(frame) * ROM_AW'(SPR_W * SPR_H)
                   + ROM_AW'(row_lo_p0) * ROM_AW'(SPR_W)
                   + ROM_AW'(colm_p0);

  // ---- stage 1: registered ROM address ----
  logic [ROM_AW-1:0] rom_addr_p1;
  logic              hit_p1;
  logic              vld_p1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr_p1 <= '0;
      hit_p1      <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      hit_p1 <= hit_p0;
      vld_p1 <= bus.pix_valid;
      if (hit_p0) rom_addr_p1 <= addr_p0;
    end
  end

  assign bus.rom_addr = rom_addr_p1;

`ifdef DREX4_SPRITE_BBOX_EN
  logic edge_p1;

  always_ff @(posedge Clk) begin
    if (Reset) edge_p1 <= 1'b0;
    else       edge_p1 <= hit_p0 &&
                          ((col_lo_p0 == '0) || (col_lo_p0 == CW'(SPR_W - 1)) ||
                           (row_lo_p0 == '0) || (row_lo_p0 == RW'(SPR_H - 1)));
  end
`endif

  // ---- stage 2: ROM word to palette index ----
  pal_idx_t index_p2;
  logic     opaque_p2;
  logic     vld_p2;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      index_p2  <= TRANSP;
      opaque_p2 <= 1'b0;
      vld_p2    <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
`ifdef DREX4_SPRITE_BBOX_EN
      if (edge_p1) begin
        index_p2  <= pal_idx_t'(BBOX_IDX);
        opaque_p2 <= 1'b1;
      end else
`endif
      if (hit_p1) begin
        index_p2  <= bus.rom_data;
        opaque_p2 <= (bus.rom_data != TRANSP);
      end else begin
        index_p2  <= TRANSP;
        opaque_p2 <= 1'b0;
      end
    end
  end

  assign bus.index       = index_p2;
  assign bus.opaque      = opaque_p2;
  assign bus.index_valid = vld_p2;

endmodule

// File: tb/tb_drex4_sprite_fetch.sv
// Directed bench for drex4_sprite_fetch with a combinational model behind the registered ROM address.
module tb_drex4_sprite_fetch;
  import drex4_pkg::*;

  localparam int ROM_AW = 12;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  drex4_sprite_fetch_if #(.ROM_AW(ROM_AW)) bus();

  drex4_sprite_fetch #(.ROM_AW(ROM_AW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  logic [3:0] rom [0:4095];
  assign bus.rom_data = rom[bus.rom_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic latch(input int x, input int y, input logic d);
    bus.pix_valid   = 1'b0;
    bus.sprite_x    = 10'(x);
    bus.sprite_y    = 10'(y);
    bus.sprite_dir  = d;
    bus.frame_start = 1'b1;
    @(negedge Clk);
    bus.frame_start = 1'b0;
    @(negedge Clk);
  endtask

  task automatic pulses(input int n);
    bus.pix_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.frame_start = 1'b1;
      @(negedge Clk);
      bus.frame_start = 1'b0;
      @(negedge Clk);
    end
  endtask

  // Called at a negedge; frame_start may already be set by the caller for the same cycle.
  task automatic pix(input string tag, input int x, input int y,
                     input int exp_addr, input int exp_idx, input logic exp_opq);
    bus.DrawX     = 10'(x);
    bus.DrawY     = 10'(y);
    bus.pix_valid = 1'b1;
    @(negedge Clk);
    bus.pix_valid   = 1'b0;
    bus.frame_start = 1'b0;
    chk({tag, "_addr"}, 32'(bus.rom_addr), 32'(exp_addr));
    @(negedge Clk);
    chk({tag, "_idx"}, 32'(bus.index), 32'(exp_idx));
    chk({tag, "_opq"}, 32'(bus.opaque), 32'(exp_opq));
    chk({tag, "_vld"}, 32'(bus.index_valid), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 4'h5;
    rom[163]  = 4'hA;
    rom[188]  = 4'hB;
    rom[164]  = 4'h0;
    rom[1187] = 4'hC;
    rom[1188] = 4'hD;
    rom[2212] = 4'hE;

    Reset           = 1'b1;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b1;
    bus.DrawX       = '0;
    bus.DrawY       = '0;
    bus.sprite_x    = '0;
    bus.sprite_y    = '0;
    bus.sprite_dir  = 1'b0;
    bus.anim_en     = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_idx",  32'(bus.index), 32'd0);
    chk("rst_opq",  32'(bus.opaque), 32'd0);
    chk("rst_vld",  32'(bus.index_valid), 32'd0);
    chk("rst_addr", 32'(bus.rom_addr), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("post_rst_vld1", 32'(bus.index_valid), 32'd0);
    chk("post_rst_idx1", 32'(bus.index), 32'd0);
    @(negedge Clk);
    chk("post_rst_vld2", 32'(bus.index_valid), 32'd1);
    chk("post_rst_idx2", 32'(bus.index), 32'h5);
    bus.pix_valid = 1'b0;
    @(negedge Clk);

    latch(100, 50, 1'b0);
    pix("hit_fwd", 103, 55, 163, 4'hA, 1'b1);
    latch(100, 50, 1'b1);
    pix("hit_mirror", 103, 55, 188, 4'hB, 1'b1);
    latch(100, 50, 1'b0);
    pix("miss_col32", 132, 55, 188, 0, 1'b0);
    latch(1000, 50, 1'b0);
    pix("miss_nowrap", 5, 55, 188, 0, 1'b0);
    latch(100, 50, 1'b0);
    pix("transp_word", 104, 55, 164, 0, 1'b0);

    bus.anim_en = 1'b1;
    pulses(8);
    pix("frame1", 103, 55, 1187, 4'hC, 1'b1);
    pulses(24);
    pix("frame_wrap", 103, 55, 163, 4'hA, 1'b1);
    pulses(7);
    bus.anim_en = 1'b0;
    pulses(5);
    pix("anim_hold", 103, 55, 163, 4'hA, 1'b1);
    bus.anim_en = 1'b1;
    pulses(1);
    bus.anim_en = 1'b0;
    pix("div_resume", 103, 55, 1187, 4'hC, 1'b1);

    bus.sprite_x    = 10'd200;
    bus.frame_start = 1'b1;
    pix("coincide_old", 103, 55, 1187, 4'hC, 1'b1);
    pix("coincide_new", 204, 55, 1188, 4'hD, 1'b1);
    pix("coincide_gone", 103, 55, 1188, 0, 1'b0);

    bus.anim_en = 1'b1;
    pulses(8);
    bus.anim_en = 1'b0;
    pix("frame2", 204, 55, 2212, 4'hE, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/drex4_sprite_fetch.md
Name: drex4_sprite_fetch

Overview:
- Upstream neighbour of the drex4 palette lookup.
- Takes the VGA beam position and produces, per pixel, the 4-bit palette index of the drex4 sprite, or a transparent index when the pixel is outside the sprite.
- Drives a synchronous sprite ROM (1-cycle read latency), latches sprite position and facing once per frame, and steps the animation frame.
- Output index feeds the palette; the opaque flag feeds the compositor mux.

Parameters:
- SPR_W, 32, sprite width in pixels (power of 2)
- SPR_H, 32, sprite height in pixels (power of 2)
- N_FRAMES, 4, animation frames stored back-to-back in ROM
- FRAME_DIV, 8, display frames per animation step (>=1)
- TRANSPARENT_IDX, 0, palette index treated as see-through
- ROM_AW, $clog2(SPR_W*SPR_H*N_FRAMES), ROM address width

Ports:
- Clk  in  1  pixel clock
- Reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- pix_valid  in  1  DrawX/DrawY is an active-area pixel
- DrawX  in  10  beam column
- DrawY  in  10  beam row
- sprite_x  in  10  sprite top-left column (game logic)
- sprite_y  in  10  sprite top-left row
- sprite_dir  in  1  1 = face left (horizontal mirror)
- anim_en  in  1  animation advances when high
- rom_addr  out  ROM_AW  sprite ROM address, registered
- rom_data  in  4  ROM word, valid one cycle after rom_addr
- index  out  4  palette index
- opaque  out  1  index is a visible sprite pixel
- index_valid  out  1  index/opaque correspond to a valid pixel

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values:
  - index=TRANSPARENT_IDX, opaque=0, index_valid=0, rom_addr=0
  - latched position/dir=0, anim frame=0, divider=0
  - all pipeline valid bits=0
- Frame latch: on a cycle with frame_start=1, register sprite_x, sprite_y and sprite_dir. Hit tests use only the latched copies, so there is no mid-frame tearing.
- Pipeline: fixed 2-cycle latency. Inputs sampled at edge t appear on the outputs after edge t+2. The pipeline advances every cycle; there is no stall. pix_valid travels as a valid bit to index_valid.
- Stage 1 (edge t+1):
  - col = DrawX - lx and row = DrawY - ly, computed in 11 bits.
  - hit = pix_valid && 0<=col<SPR_W && 0<=row<SPR_H. There is no wrap: sprite_x=1000 with DrawX=5 is a miss.
  - colm = dir ? SPR_W-1-col : col.
  - rom_addr <= frame*SPR_W*SPR_H + row*SPR_W + colm on a hit; otherwise rom_addr holds its value.
  - hit and valid are registered alongside.
- Stage 2 (edge t+2):
  - On a hit: index <= rom_data; opaque <= (rom_data != TRANSPARENT_IDX).
  - On a miss: index <= TRANSPARENT_IDX; opaque <= 0.
  - index_valid <= the stage-1 valid bit.
- Animation, evaluated on a frame_start with anim_en=1:
  - div <= div+1.
  - When div==FRAME_DIV-1: div <= 0 and frame <= (frame+1) mod N_FRAMES.
  - With anim_en=0, div and frame hold.
- Simultaneous frame_start and pix_valid: that pixel uses the old latched values; new values apply from the next cycle.
- Reset mid-line: in-flight pixels are discarded. index_valid=0 for the two cycles after Reset deasserts.

Optional Feature:
- Macro DREX4_SPRITE_BBOX_EN.
- Defined: hit pixels with col or row equal to 0 or to SPR_W-1/SPR_H-1 output index 6 with opaque=1, regardless of rom_data. This is a bounding-box debug outline.
- Undefined: no outline logic; behaviour exactly as above.

Decomposition:
- drex4_pkg:
  - SPR_W, SPR_H, N_FRAMES, TRANSPARENT_IDX, BBOX_IDX=6
  - typedef logic [3:0] pal_idx_t
  - typedef logic [9:0] coord_t
- Sub-module drex4_anim_ctr: the frame_start/anim_en divider and frame counter. Outputs the frame number; separately testable.

Test Plan:
- Reset held 3 cycles, then released with pix_valid=1 -> index_valid=0 for the first 2 cycles, index=0, opaque=0.
- Latch (100,50), dir=0, frame 0, ROM word at address 5*32+3=163 = 4'hA; DrawX=103, DrawY=55 at cycle t -> rom_addr=163 after t+1; index=A, opaque=1, index_valid=1 after t+2.
- Same latch with dir=1, DrawX=103, DrawY=55 -> rom_addr=5*32+28=188.
- DrawX=132, DrawY=55 (col=32) -> miss: index=0, opaque=0, rom_addr unchanged. Latch x=1000 with DrawX=5 -> miss.
- ROM word = 0 inside the sprite -> index=0, opaque=0, index_valid=1.
- FRAME_DIV=8, anim_en=1:
  - 8 frame_start pulses -> frame 1; 32 pulses -> frame 0 (wrap); rom_addr offset steps by 1024 per frame.
  - anim_en=0 for 5 pulses -> no change.
  - frame_start coincident with a pixel -> that pixel uses the old position.
